accum_drain_serializer: RTL
===========================

// Module: accum_drain_serializer
// PURPOSE
//  Read side of the double-buffered accumulator. Takes the row stream
//  (valid + two signed 32-bit columns) that the accumulator emits with no
//  backpressure and buffers it in a small FIFO. Each column is requantized
//  (rounding shift, optional ReLU, int8 saturation). Rows go out as a
//  byte-wide valid/ready stream, col0 then col1, with a tile-end marker.
// PARAMETERS
//  DEPTH   4  FIFO depth in rows; power of 2, >= 2
//  ROW_W   8  width of cfg_rows and of the internal row counter
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high
//  in_valid   in   1      row valid (driven by accumulator valid_out)
//  in_col0    in   32     signed accumulator column 0
//  in_col1    in   32     signed accumulator column 1
//  cfg_shift  in   5      arithmetic right-shift amount, 0..31
//  cfg_relu   in   1      1: negative inputs clamp to 0 before shift
//  cfg_rows   in   ROW_W  rows per tile; 0 = out_last never asserted
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts the beat when out_valid&&out_ready
//  out_data   out  8      signed int8 result
//  out_last   out  1      high on the final beat (col1) of the tile's last row
//  overflow   out  1      sticky; a row arrived while the FIFO was full
//  fifo_count out  $clog2(DEPTH)+1  rows held in the FIFO (excludes holding reg)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_last=0, overflow=0, FIFO empty,
//   fifo_count=0, row counter=0, FSM=IDLE. All outputs are registered.
//  FIFO write: on in_valid when not full (full = pre-edge state). A write
//   while full is dropped and sets overflow=1, even if a pop happens in
//   the same cycle. Push and pop in the same cycle are allowed when not full.
//  Requant per column x (config sampled at pop time):
//   x' = (cfg_relu && x<0) ? 0 : x
//   r  = (cfg_shift==0) ? x' : (x' + (1<<(cfg_shift-1))) >>> cfg_shift
//   Compute in 33 bits (no wrap). Saturate r to [-128,127].
//  FSM, with holding regs q0/q1 (int8):
//   IDLE: if FIFO non-empty, pop head into q0/q1. Next state COL0,
//    out_valid=1, out_data=q0.
//   COL0: hold out_data until out_ready. On accept: COL1, out_data=q1.
//   COL1: on accept, if FIFO non-empty pop and go to COL0 with no bubble.
//    Otherwise go to IDLE with out_valid=0.
//  out_data and out_last are stable while out_valid && !out_ready.
//  Latency: in_valid at cycle t -> out_valid first seen at cycle t+2
//   (empty FIFO, idle FSM). Sustained rate: 1 beat/cycle with
//   out_ready=1. Input rate of more than 1 row per 2 cycles eventually
//   fills the FIFO.
//  Row counter: increments when a COL1 beat is accepted. out_last=1 on a
//   COL1 beat when counter==cfg_rows-1. The counter returns to 0 after
//   that beat. cfg_rows changes take effect on the next compare.
//  Reset mid-stream: all state is discarded, including rows held in the
//   FIFO and the holding regs, and the partially emitted row.
// TESTING
//  1 shift=0, relu=0, row(5,-3), out_ready=1 -> out_valid at t+2,
//    beats 0x05 then 0xFD.
//  2 shift=4: 40->3, -40->-2. shift=0: 1000->127, -1000->-128.
//    relu=1, shift=0: -1000->0.
//  3 out_ready=0 for 5 cycles during COL0 -> out_data and out_valid held.
//    Release -> col0, col1 each delivered exactly once.
//  4 DEPTH=4, out_ready=0, 6 rows on consecutive cycles -> row5 dropped,
//    overflow=1, fifo_count=4. Drain -> 10 beats (rows 0..4) in order.
//  5 cfg_rows=3, 3 back-to-back rows, out_ready=1 -> 6 beats on
//    consecutive cycles. out_last=1 only on beat 6; the next tile restarts.
//  6 assert reset during COL1 with 2 rows queued -> next cycle: all
//    outputs 0, fifo_count=0. A new row afterwards behaves as in test 1.

Source files
------------

// File: rtl/accum_drain_serializer.sv
// Read side of the double-buffered accumulator: buffers two-column rows in a FIFO,
// requantizes each column to int8 and serializes them as a byte stream with a tile-end marker.
module accum_drain_serializer #(
  parameter int DEPTH = 4,
  parameter int ROW_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [31:0]        in_col0,
  input  logic signed [31:0]        in_col1,
  input  logic        [4:0]         cfg_shift,
  input  logic                      cfg_relu,
  input  logic        [ROW_W-1:0]   cfg_rows,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [7:0]         out_data,
  output logic                      out_last,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COL0, COL1} state_t;

  // 33-bit intermediate so the rounding bias can never wrap a 32-bit column.
  function automatic logic signed [32:0] round_shift(input logic signed [31:0] x,
                                                      input logic [4:0] sh,
                                                      input logic relu);
    logic signed [32:0] xr;
    logic signed [32:0] bias;
    xr = (relu && x < 0) ? 33'sd0 : {x[31], x};
    if (sh == 5'd0) return xr;
    bias = 33'sd1 <<< (sh - 5'd1);
    return (xr + bias) >>> sh;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [32:0] r);
    if (r > 33'sd127) return 8'sd127;
    else if (r < -33'sd128) return -8'sd128;
    else return r[7:0];
  endfunction

  logic signed [31:0] mem0 [DEPTH];
  logic signed [31:0] mem1 [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  state_t             state;
  logic signed [7:0]  q1;
  logic [ROW_W-1:0]   row_cnt;
  logic               last_hit;
  logic signed [7:0]  rq0_p0;
  logic signed [7:0]  rq1_p0;

  assign full  = (fifo_count == (AW+1)'(DEPTH));
  assign empty = (fifo_count == '0);
  assign push  = in_valid && !full;
  assign pop   = !empty && ((state == IDLE) || (state == COL1 && out_ready));

  // Requantize the FIFO head with the configuration current at pop time.
  assign rq0_p0 = sat8(round_shift(mem0[rd_ptr], cfg_shift, cfg_relu));
  assign rq1_p0 = sat8(round_shift(mem1[rd_ptr], cfg_shift, cfg_relu));

  assign last_hit = (cfg_rows != '0) && (row_cnt == cfg_rows - ROW_W'(1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr_ptr] <= in_col0;
      mem1[wr_ptr] <= in_col1;
    end
  end

  // A write while full is lost even if a pop frees a slot on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (in_valid && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      q1        <= '0;
      row_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            q1        <= rq1_p0;
            out_data  <= rq0_p0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= COL0;
          end
        end
        COL0: begin
          if (out_ready) begin
            out_data <= q1;
            out_last <= last_hit;
            state    <= COL1;
          end
        end
        COL1: begin
          if (out_ready) begin
            row_cnt <= out_last ? '0 : row_cnt + ROW_W'(1);
            if (!empty) begin
              // Back-to-back rows: next col0 follows without a bubble.
              q1       <= rq1_p0;
              out_data <= rq0_p0;
              out_last <= 1'b0;
              state    <= COL0;
            end else begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
